// File: rtl/led_mode_ctrl_pkg.sv
// Shared definitions for the running-light sequencer: FSM states, mode codes,
// initial lamp patterns, default timing, and small decode helpers.
package led_mode_ctrl_pkg;

   // Defaults for a 50 MHz clock: 20 ms debounce, 0.5 s per step.
   localparam int unsigned DEB_CNT_DEFAULT  = 1_000_000;
   localparam int unsigned STEP_CNT_DEFAULT = 25_000_000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEFT,
      ST_RIGHT,
      ST_BLINK,
      ST_BOUNCE
   } state_e;

   typedef enum logic [1:0] {
      MODE_LEFT   = 2'd0,
      MODE_RIGHT  = 2'd1,
      MODE_BLINK  = 2'd2,
      MODE_BOUNCE = 2'd3
   } mode_e;

   localparam logic [3:0] PAT_LEFT_INIT   = 4'b0001;
   localparam logic [3:0] PAT_RIGHT_INIT  = 4'b1000;
   localparam logic [3:0] PAT_BLINK_INIT  = 4'b1111;
   localparam logic [3:0] PAT_BOUNCE_INIT = 4'b0001;

   // Keep only the lowest set bit, so simultaneous presses resolve to key0 first.
   function automatic logic [3:0] lowest_set(input logic [3:0] v);
      return v & (~v + 4'd1);
   endfunction

   // Map a one-hot press vector to the run state it selects.
   function automatic state_e key_to_state(input logic [3:0] press);
      state_e s;
      s = ST_IDLE;
      if (press[0])      s = ST_LEFT;
      else if (press[1]) s = ST_RIGHT;
      else if (press[2]) s = ST_BLINK;
      else if (press[3]) s = ST_BOUNCE;
      return s;
   endfunction

   function automatic logic [3:0] initial_pattern(input state_e s);
      logic [3:0] p;
      case (s)
         ST_LEFT:   p = PAT_LEFT_INIT;
         ST_RIGHT:  p = PAT_RIGHT_INIT;
         ST_BLINK:  p = PAT_BLINK_INIT;
         ST_BOUNCE: p = PAT_BOUNCE_INIT;
         default:   p = 4'b0000;
      endcase
      return p;
   endfunction

   // IDLE reports mode 0; active distinguishes it from LEFT.
   function automatic mode_e state_to_mode(input state_e s);
      mode_e m;
      case (s)
         ST_RIGHT:  m = MODE_RIGHT;
         ST_BLINK:  m = MODE_BLINK;
         ST_BOUNCE: m = MODE_BOUNCE;
         default:   m = MODE_LEFT;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/led_mode_ctrl_key_debounce.sv
// Key conditioning: two-flop synchroniser, one shared debounce counter over
// the whole 4-bit key vector, and falling-edge (press) detection.
module key_debounce
   import led_mode_ctrl_pkg::*;
#(
   parameter int unsigned DEB_CNT = DEB_CNT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] key_i,
   output logic [3:0] press_o
);

   localparam int unsigned   CW       = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

   logic [3:0]    meta_q, sync_q;
   logic [3:0]    stable_q, stable_d;
   logic [3:0]    press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Debounce next-state: count while the synchronised vector is steady and
   // differs from the accepted one; any change in it restarts the count.
   always_comb begin
      // NOTE: every output gets a default first, so no path leaves one unassigned
      // and no latch is inferred.
      cnt_d    = '0;
      stable_d = stable_q;
      press_d  = '0;
      if (meta_q == sync_q && sync_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync_q;
            // Press = 1->0 transition; releases are ignored.
            press_d  = lowest_set(stable_q & ~sync_q);
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Synchroniser, debounce state and registered press pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state updates use non-blocking assignment so every flop samples
      // the pre-edge values, independent of statement order.
      if (!rst_n) begin
         meta_q   <= 4'b1111;
         sync_q   <= 4'b1111;
         stable_q <= 4'b1111;
         press_q  <= 4'b0000;
         cnt_q    <= '0;
      end else begin
         meta_q   <= key_i;
         sync_q   <= meta_q;
         stable_q <= stable_d;
         press_q  <= press_d;
         cnt_q    <= cnt_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// Running-light sequencer top: mode FSM, step counter and lamp pattern
// registers, fed by debounced key press pulses.
module led_mode_ctrl
   import led_mode_ctrl_pkg::*;
#(
   parameter int unsigned DEB_CNT  = DEB_CNT_DEFAULT,
   parameter int unsigned STEP_CNT = STEP_CNT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] key,
   output logic [3:0] led,
   output logic [1:0] mode,
   output logic       active,
   output logic       step_tick
);

   localparam int unsigned   SW        = (STEP_CNT > 1) ? $clog2(STEP_CNT) : 1;
   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CNT - 1);

   logic [3:0]    press;
   state_e        state_q, state_d;
   logic [SW-1:0] step_q, step_d;
   logic [3:0]    led_q, led_d;
   logic          dir_q, dir_d;     // bounce direction: 0 toward lamp 3, 1 toward lamp 0
   logic          tick;

   key_debounce #(.DEB_CNT(DEB_CNT)) u_key_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_i   (key),
      .press_o (press)
   );

   // Next state, step count and pattern; a press outranks a pending step.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      led_d   = led_q;
      dir_d   = dir_q;
      tick    = 1'b0;
      if (press != 4'b0000) begin
         state_d = key_to_state(press);
         step_d  = '0;
         led_d   = initial_pattern(state_d);
         dir_d   = 1'b0;
      end else if (state_q != ST_IDLE) begin
         if (step_q == STEP_LAST) begin
            step_d = '0;
            tick   = 1'b1;
            case (state_q)
               ST_LEFT:  led_d = {led_q[2:0], led_q[3]};
               ST_RIGHT: led_d = {led_q[0], led_q[3:1]};
               ST_BLINK: led_d = ~led_q;
               ST_BOUNCE: begin
                  if (!dir_q) begin
                     if (led_q == 4'b1000) begin
                        dir_d = 1'b1;
                        led_d = led_q >> 1;
                     end else begin
                        led_d = led_q << 1;
                     end
                  end else begin
                     if (led_q == 4'b0001) begin
                        dir_d = 1'b0;
                        led_d = led_q << 1;
                     end else begin
                        led_d = led_q >> 1;
                     end
                  end
               end
               default: led_d = 4'b0000;
            endcase
         end else begin
            step_d = step_q + SW'(1);
         end
      end
   end

   // State, step counter and lamp registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
         led_q   <= 4'b0000;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         led_q   <= led_d;
         dir_q   <= dir_d;
      end
   end

   assign led       = led_q;
   assign mode      = state_to_mode(state_q);
   assign active    = (state_q != ST_IDLE);
   assign step_tick = tick;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Self-checking bench for led_mode_ctrl with short debounce and step periods.
// A pattern model predicts each lamp step when step_tick fires and queues it;
// the monitor pops and compares after the step edge.
`timescale 1ns/1ps
module tb_led_mode_ctrl;

   localparam int DEB = 4;
   localparam int STP = 5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] key;
   logic [3:0] led;
   logic [1:0] mode;
   logic       active;
   logic       step_tick;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Pattern model: sequence tables per mode, independent of the shift logic.
   logic [3:0] seq [0:3][0:5] = '{
      '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0},
      '{4'h8, 4'h4, 4'h2, 4'h1, 4'h0, 4'h0},
      '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0},
      '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2}
   };
   int seq_len [0:3] = '{4, 4, 2, 6};

   int         exp_mode   = -1;   // -1 means IDLE
   int         exp_idx    = 0;
   int         last_tick  = 0;
   int         steps_seen = 0;
   logic [3:0] exp_q [$];

   always #10 clk = ~clk;

   led_mode_ctrl #(.DEB_CNT(DEB), .STEP_CNT(STP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key       (key),
      .led       (led),
      .mode      (mode),
      .active    (active),
      .step_tick (step_tick)
   );

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Scoreboard monitor: compare the queued step result, then predict the next.
   initial begin
      logic [3:0] e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
         end else begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               n_assert++;
               if (led !== e) begin
                  n_fail++;
                  $display("FAIL step_led: led=%b expected %b (cycle %0d)", led, e, cyc);
               end
            end
            if (step_tick === 1'b1) begin
               n_assert++;
               if (exp_mode < 0) begin
                  n_fail++;
                  $display("FAIL idle_tick: step_tick=1 while expected IDLE (cycle %0d)", cyc);
               end else begin
                  if (cyc - last_tick != STP) begin
                     n_fail++;
                     $display("FAIL tick_spacing: %0d cycles since last step, expected %0d", cyc - last_tick, STP);
                  end
                  last_tick = cyc;
                  exp_idx   = (exp_idx + 1) % seq_len[exp_mode];
                  exp_q.push_back(seq[exp_mode][exp_idx]);
                  steps_seen++;
               end
            end
         end
      end
   end

   // Watchdog: the run is short; anything past this is a hang.
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Model now starts mode m at the entry edge just observed.
   task automatic set_model(input int m);
      exp_mode  = m;
      exp_idx   = 0;
      last_tick = cyc - 1;
   endtask

   // Drive a key vector and wait out the full press-to-lamp latency.
   task automatic press_keys(input logic [3:0] v);
      @(negedge clk);
      key = v;
      repeat (DEB + 3) @(posedge clk);
      #1;
   endtask

   task automatic release_keys();
      @(negedge clk);
      key = 4'b1111;
      repeat (DEB + 4) @(posedge clk);
      #1;
   endtask

   // Wait for n model steps, bounded.
   task automatic wait_steps(input int n);
      int target;
      target = steps_seen + n;
      for (int i = 0; i < (n + 2) * STP + 5 && steps_seen < target; i++) @(posedge clk);
      @(negedge clk);
      n_assert++;
      if (steps_seen < target) begin
         n_fail++;
         $display("FAIL step_timeout: saw %0d steps, expected %0d", steps_seen - target + n, n);
      end
   endtask

   task automatic test_reset();
      logic seen_tick, seen_led;
      key   = 4'b1111;
      rst_n = 1'b0;
      #5;
      n_assert++;
      if (led !== 4'b0000 || mode !== 2'd0 || active !== 1'b0 || step_tick !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: led=%b mode=%0d active=%b tick=%b expected 0000/0/0/0", led, mode, active, step_tick);
      end
      #20 rst_n = 1'b1;
      seen_tick = 1'b0;
      seen_led  = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (step_tick) seen_tick = 1'b1;
         if (led != 4'b0000 || active) seen_led = 1'b1;
      end
      n_assert++;
      if (seen_tick !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_no_tick: step_tick seen=%b expected 0", seen_tick);
      end
      n_assert++;
      if (seen_led !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_quiet: led/active activity=%b expected 0", seen_led);
      end
   endtask

   task automatic test_left();
      @(negedge clk);
      key = 4'b1110;
      repeat (DEB + 2) @(posedge clk);
      #1;
      n_assert++;
      if (led !== 4'b0000 || active !== 1'b0) begin
         n_fail++;
         $display("FAIL left_early: led=%b active=%b expected 0000/0 one edge before latency", led, active);
      end
      @(posedge clk);
      #1;
      n_assert++;
      if (led !== 4'b0001 || active !== 1'b1 || mode !== 2'd0) begin
         n_fail++;
         $display("FAIL left_entry: led=%b active=%b mode=%0d expected 0001/1/0", led, active, mode);
      end
      set_model(0);
      wait_steps(4);
   endtask

   task automatic test_glitch_then_right();
      @(negedge clk);
      key = 4'b1101;
      repeat (2) @(posedge clk);
      @(negedge clk);
      key = 4'b1111;
      repeat (DEB + 8) @(posedge clk);
      #1;
      n_assert++;
      if (mode !== 2'd0 || active !== 1'b1) begin
         n_fail++;
         $display("FAIL glitch_ignored: mode=%0d active=%b expected 0/1", mode, active);
      end
      press_keys(4'b1101);
      n_assert++;
      if (led !== 4'b1000 || mode !== 2'd1) begin
         n_fail++;
         $display("FAIL right_entry: led=%b mode=%0d expected 1000/1", led, mode);
      end
      set_model(1);
      wait_steps(4);
   endtask

   task automatic test_simultaneous();
      release_keys();
      press_keys(4'b1100);
      n_assert++;
      if (led !== 4'b0001 || mode !== 2'd0) begin
         n_fail++;
         $display("FAIL simul_lowest: led=%b mode=%0d expected 0001/0", led, mode);
      end
      set_model(0);
      @(negedge clk);
      key = 4'b1101;
      repeat (DEB + 8) @(posedge clk);
      #1;
      n_assert++;
      if (mode !== 2'd0) begin
         n_fail++;
         $display("FAIL simul_release: mode=%0d expected 0 after releasing key0", mode);
      end
      wait_steps(2);
   endtask

   task automatic test_bounce_restart();
      release_keys();
      press_keys(4'b0111);
      n_assert++;
      if (led !== 4'b0001 || mode !== 2'd3) begin
         n_fail++;
         $display("FAIL bounce_entry: led=%b mode=%0d expected 0001/3", led, mode);
      end
      set_model(3);
      wait_steps(8);
      release_keys();
      press_keys(4'b0111);
      n_assert++;
      if (led !== 4'b0001 || mode !== 2'd3) begin
         n_fail++;
         $display("FAIL bounce_restart: led=%b mode=%0d expected 0001/3", led, mode);
      end
      set_model(3);
      wait_steps(3);
   endtask

   task automatic test_async_reset();
      release_keys();
      press_keys(4'b1011);
      n_assert++;
      if (led !== 4'b1111 || mode !== 2'd2) begin
         n_fail++;
         $display("FAIL blink_entry: led=%b mode=%0d expected 1111/2", led, mode);
      end
      set_model(2);
      wait_steps(1);
      repeat (2) @(posedge clk);
      #5;
      rst_n    = 1'b0;
      exp_mode = -1;
      #1;
      n_assert++;
      if (led !== 4'b0000 || active !== 1'b0 || mode !== 2'd0) begin
         n_fail++;
         $display("FAIL async_reset: led=%b active=%b mode=%0d expected 0000/0/0", led, active, mode);
      end
      key = 4'b1111;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      n_assert++;
      if (led !== 4'b0000 || active !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_idle: led=%b active=%b expected 0000/0", led, active);
      end
   endtask

   initial begin
      test_reset();
      test_left();
      test_glitch_then_right();
      test_simultaneous();
      test_bounce_restart();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
